// File: rtl/audio_sample_queue_if.sv
// Sample/replay bundle between the sample source and the stereo queue.
// The source drives the master side; the queue is the slave.
interface audio_sample_queue_if;
   logic               wrt_smpl;
   logic signed [15:0] lft_smpl;
   logic signed [15:0] rght_smpl;
   logic signed [15:0] lft_out;
   logic signed [15:0] rght_out;
   logic               sequencing;
   logic               ovr;

   modport master (
      output wrt_smpl,
      output lft_smpl,
      output rght_smpl,
      input  lft_out,
      input  rght_out,
      input  sequencing,
      input  ovr
   );

   modport slave (
      input  wrt_smpl,
      input  lft_smpl,
      input  rght_smpl,
      output lft_out,
      output rght_out,
      output sequencing,
      output ovr
   );
endinterface

// File: rtl/audio_sample_queue.sv
// Stereo circular sample queue that replays the newest READ_LEN pairs per write.
// Define QUEUE_DECIMATE_EN to store only every second strobe (half rate band).
module audio_sample_queue #(
   parameter int DEPTH    = 1024,
   parameter int READ_LEN = 1021
) (
   input logic clk,
   input logic rst_n,
   audio_sample_queue_if.slave q
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(READ_LEN + 1);

   typedef enum logic {
      IDLE,
      SEQ
   } state_t;

   logic signed [15:0] mem_l [DEPTH];
   logic signed [15:0] mem_r [DEPTH];

   state_t             state_q;
   logic [AW-1:0]      new_ptr_q, new_ptr_d;
   logic [AW-1:0]      rd_ptr_q;
   logic [AW-1:0]      rd_addr;
   logic [CW-1:0]      fill_q, fill_d;
   logic [CW-1:0]      cnt_q;
   logic               seq_q;
   logic               ovr_q;
   logic signed [15:0] lft_q;
   logic signed [15:0] rght_q;
   logic               wr_en;
   logic               rd_en;
   logic               start;

`ifdef QUEUE_DECIMATE_EN
   logic phase_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= 1'b0;
      end else if (q.wrt_smpl) begin
         phase_q <= ~phase_q;
      end
   end

   assign wr_en = q.wrt_smpl & phase_q;
`else
   assign wr_en = q.wrt_smpl;
`endif

   always_comb begin
      new_ptr_d = new_ptr_q + AW'(1);
      fill_d    = fill_q;
      if (fill_q != CW'(READ_LEN)) begin
         fill_d = fill_q + CW'(1);
      end
      rd_addr = rd_ptr_q + AW'(cnt_q);
      rd_en   = (state_q == SEQ) && (cnt_q != CW'(READ_LEN));
      start   = wr_en && (state_q == IDLE)
             && (fill_d == CW'(READ_LEN));
   end

   // Storage is deliberately unreset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_l[new_ptr_q] <= q.lft_smpl;
         mem_r[new_ptr_q] <= q.rght_smpl;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_q  <= '0;
         rght_q <= '0;
      end else if (rd_en) begin
         lft_q  <= mem_l[rd_addr];
         rght_q <= mem_r[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         new_ptr_q <= '0;
         fill_q    <= '0;
      end else if (wr_en) begin
         new_ptr_q <= new_ptr_d;
         fill_q    <= fill_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         seq_q    <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q  <= SEQ;
                  rd_ptr_q <= new_ptr_d - AW'(READ_LEN);
                  cnt_q    <= '0;
                  seq_q    <= 1'b1;
               end
            end
            SEQ: begin
               // The final cycle still belongs to the replay.
               if (wr_en) begin
                  ovr_q <= 1'b1;
               end
               if (cnt_q == CW'(READ_LEN)) begin
                  state_q <= IDLE;
                  seq_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign q.lft_out    = lft_q;
   assign q.rght_out   = rght_q;
   assign q.sequencing = seq_q;
   assign q.ovr        = ovr_q;

endmodule

// File: tb/tb_audio_sample_queue.sv
// Bench for audio_sample_queue: directed plan plus random writes,
// checked every cycle against a queue-based model of the replay rules.
module tb_audio_sample_queue;

   localparam int DEPTH = 16;
   localparam int RL    = 13;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   audio_sample_queue_if qif ();

   audio_sample_queue #(
      .DEPTH   (DEPTH),
      .READ_LEN(RL)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .q    (qif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0]        hist[$];
   logic [31:0]        win[$];
   int                 fill;
   int                 seq_k;
   logic signed [15:0] exp_l;
   logic signed [15:0] exp_r;
   logic               exp_ovr;
   logic               phase;

   task automatic model_reset();
      hist.delete();
      win.delete();
      fill    = 0;
      seq_k   = -1;
      exp_l   = '0;
      exp_r   = '0;
      exp_ovr = 1'b0;
      phase   = 1'b0;
   endtask

   task automatic check(input string tag);
      logic es;
      es = (seq_k >= 0);
      checks += 4;
      assert (qif.sequencing === es) else begin
         errors++;
         $error("FAIL %s seq got %0b exp %0b", tag, qif.sequencing, es);
      end
      assert (qif.lft_out === exp_l) else begin
         errors++;
         $error("FAIL %s lft got %0d exp %0d", tag, qif.lft_out, exp_l);
      end
      assert (qif.rght_out === exp_r) else begin
         errors++;
         $error("FAIL %s rght got %0d exp %0d", tag, qif.rght_out, exp_r);
      end
      assert (qif.ovr === exp_ovr) else begin
         errors++;
         $error("FAIL %s ovr got %0b exp %0b", tag, qif.ovr, exp_ovr);
      end
   endtask

   // Advance the model across one clock edge with the given strobe.
   task automatic model_edge(input logic w, input logic [15:0] l,
                             input logic [15:0] r);
      logic st;
      int   k0;
      st = w;
`ifdef QUEUE_DECIMATE_EN
      if (w) begin
         st    = phase;
         phase = ~phase;
      end
`endif
      k0 = seq_k;
      if (k0 >= 0 && k0 < RL) begin
         exp_l = win[k0][31:16];
         exp_r = win[k0][15:0];
      end
      if (st) begin
         hist.push_back({l, r});
         if (hist.size() > 64) void'(hist.pop_front());
         if (fill < RL) fill++;
         if (k0 >= 0) exp_ovr = 1'b1;
      end
      if (k0 >= 0) begin
         seq_k = (k0 == RL) ? -1 : k0 + 1;
      end else if (st && fill == RL) begin
         seq_k = 0;
         win.delete();
         for (int i = hist.size() - RL; i < hist.size(); i++)
            win.push_back(hist[i]);
      end
   endtask

   task automatic step(input logic w, input logic [15:0] l,
                       input logic [15:0] r, input string tag);
      @(negedge clk);
      check(tag);
      qif.wrt_smpl  = w;
      qif.lft_smpl  = l;
      qif.rght_smpl = r;
      model_edge(w, l, r);
   endtask

   task automatic idle(input int n, input string tag);
      repeat (n) step(1'b0, 16'h0, 16'h0, tag);
   endtask

   task automatic wr(input int v, input int gap, input string tag);
      step(1'b1, 16'(v), 16'(-v), tag);
      idle(gap, tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      check(tag);
      qif.wrt_smpl = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check({tag, "_async"});
      @(negedge clk);
      check({tag, "_held"});
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      qif.wrt_smpl  = 1'b0;
      qif.lft_smpl  = '0;
      qif.rght_smpl = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset");
      rst_n = 1'b1;

      for (int v = 1; v <= 12; v++) wr(v, 2, "fill");
      wr(13, 20, "first_seq");
      for (int v = 14; v <= 20; v++) wr(v, 30, "wrap");

      step(1'b1, 16'(21), 16'(-21), "ovr_start");
      idle(5, "ovr_pre");
      step(1'b1, 16'(22), 16'(-22), "ovr_hit");
      idle(20, "ovr_post");
      wr(23, 20, "after_ovr");

      step(1'b1, 16'(24), 16'(-24), "rst_seq");
      idle(6, "rst_pre");
      do_reset("mid_rst");
      for (int v = 1; v <= 12; v++) wr(v, 3, "refill");
      wr(13, 20, "refill_seq");

`ifdef QUEUE_DECIMATE_EN
      do_reset("dec_rst");
      for (int v = 1; v <= 26; v++) wr(v, 1, "dec_fill");
      idle(20, "dec_seq");
`endif

      for (int n = 0; n < 40; n++) begin
         step(1'b1, 16'($urandom), 16'($urandom), "rand_wr");
         idle(int'($urandom_range(8, 30)), "rand_idle");
      end
      idle(20, "drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
